mem_cmd_scheduler: RTL

MEM_CMD_SCHEDULER -- requirements
Module: mem_cmd_scheduler

---
 rtl/mem_ctrl_pkg.sv | 44 ++++
 rtl/req_queue.sv | 65 ++++++
 rtl/mem_cmd_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory command scheduler:
// request/command encodings, the request record, address-field layout
// and default DRAM timing values (all in clk cycles).
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_t;

  // One trace request: earliest issue cycle, operation, byte address.
  typedef struct packed {
    logic [31:0] issue_time;
    op_t         op;
    logic [31:0] addr;
  } mem_req_t;

  // Address layout: row | bank | bank group | column | byte-in-beat.
  localparam int ROW_LSB  = 17;
  localparam int ROW_W    = 15;
  localparam int BANK_LSB = 15;
  localparam int BANK_W   = 2;
  localparam int BG_LSB   = 13;
  localparam int BG_W     = 2;
  localparam int COL_LSB  = 3;
  localparam int COL_W    = 10;

  localparam int DEF_QUEUE_DEPTH = 16;
  localparam int DEF_T_RCD       = 4;
  localparam int DEF_T_CL        = 5;
  localparam int DEF_T_CWL       = 4;
  localparam int DEF_T_BURST     = 4;
  localparam int DEF_T_RP        = 4;

endpackage

// File: rtl/req_queue.sv
// In-order request FIFO. Head is read combinationally from the storage
// array; an entry written in one cycle is only visible at the head from
// the next cycle, since empty/count come from registered state.
module req_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 66,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer and occupancy update; simultaneous push+pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_cmd_scheduler.sv
// Closed-page DRAM command scheduler: queues timed trace requests and
// replays each as ACT -> CAS (RD/WR) -> PRE with fixed timing gaps.
// Optional macro SCHED_DEBUG_EN adds a simulation log of issued commands
// and dropped illegal requests; behaviour is otherwise identical.
module mem_cmd_scheduler
  import mem_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int T_RCD       = DEF_T_RCD,
  parameter int T_CL        = DEF_T_CL,
  parameter int T_CWL       = DEF_T_CWL,
  parameter int T_BURST     = DEF_T_BURST,
  parameter int T_RP        = DEF_T_RP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_time,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  output logic        cmd_valid,
  output logic [1:0]  cmd,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [14:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic [4:0]  q_count,
  output logic [31:0] sim_time,
  output logic        busy
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACT, ST_WAIT_RCD, ST_CAS, ST_WAIT_CAS, ST_PRE, ST_WAIT_RP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       sim_time_q, sim_time_d;
  logic              wr_q, wr_d;
  logic [BG_W-1:0]   bg_q, bg_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;

  logic [$bits(mem_req_t)-1:0] q_rd_data;
  logic [$clog2(QUEUE_DEPTH):0] q_cnt;
  logic     q_full, q_empty, q_push, q_pop;
  mem_req_t head, push_req;
  cmd_t     cmd_c;
  logic     unused_addr_lsbs;

  assign req_ready = en && !q_full;
  // Illegal op 3 is accepted on the handshake but never stored.
  assign q_push    = req_valid && req_ready && (req_op != 2'd3);
  assign push_req  = '{issue_time: req_time, op: op_t'(req_op), addr: req_addr};
  assign head      = mem_req_t'(q_rd_data);
  assign q_count   = 5'(q_cnt);
  assign sim_time  = sim_time_q;
  assign unused_addr_lsbs = ^head.addr[COL_LSB-1:0];

  req_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(mem_req_t))
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (push_req),
    .pop       (q_pop),
    .pop_data  (q_rd_data),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_cnt)
  );

  // Cycle counter: advances only while enabled, sticks at all-ones.
  always_comb begin
    sim_time_d = sim_time_q;
    if (en && (sim_time_q != '1)) sim_time_d = sim_time_q + 32'd1;
  end

  // Sequencer next state: dispatch, then count down each timing gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    bg_d    = bg_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    q_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !q_empty && (sim_time_q >= head.issue_time)) begin
          q_pop   = 1'b1;
          wr_d    = (head.op == OP_WRITE);
          row_d   = head.addr[ROW_LSB +: ROW_W];
          bank_d  = head.addr[BANK_LSB +: BANK_W];
          bg_d    = head.addr[BG_LSB +: BG_W];
          col_d   = head.addr[COL_LSB +: COL_W];
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        cnt_d   = CW'(T_RCD - 2);
        state_d = ST_WAIT_RCD;
      end
      ST_WAIT_RCD: begin
        if (cnt_q == '0) state_d = ST_CAS;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_CAS: begin
        cnt_d   = wr_q ? CW'(T_CWL + T_BURST - 2) : CW'(T_CL + T_BURST - 2);
        state_d = ST_WAIT_CAS;
      end
      ST_WAIT_CAS: begin
        if (cnt_q == '0) state_d = ST_PRE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_PRE: begin
        cnt_d   = CW'(T_RP - 2);
        state_d = ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command outputs: strobe in ACT/CAS/PRE, fields valid from ACT through PRE.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_c     = CMD_ACT;
    cmd_bg    = '0;
    cmd_bank  = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_ACT: begin cmd_valid = 1'b1; cmd_c = CMD_ACT; end
      ST_CAS: begin cmd_valid = 1'b1; cmd_c = wr_q ? CMD_WR : CMD_RD; end
      ST_PRE: begin cmd_valid = 1'b1; cmd_c = CMD_PRE; end
      default: ;
    endcase
    if (state_q inside {ST_ACT, ST_WAIT_RCD, ST_CAS, ST_WAIT_CAS, ST_PRE}) begin
      cmd_bg   = bg_q;
      cmd_bank = bank_q;
      cmd_row  = row_q;
      cmd_col  = col_q;
    end
  end

  assign cmd = cmd_c;

  // State registers; reset abandons any in-flight sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sim_time_q <= '0;
      wr_q       <= 1'b0;
      bg_q       <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sim_time_q <= sim_time_d;
      wr_q       <= wr_d;
      bg_q       <= bg_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

`ifdef SCHED_DEBUG_EN
  // Simulation log of issued commands and dropped illegal requests.
  always @(posedge clk) begin
    if (rst_n && cmd_valid)
      $display("[%08h] %s bg=%h bank=%h row=%h col=%h",
               sim_time, cmd_c.name(), cmd_bg, cmd_bank, cmd_row, cmd_col);
    if (rst_n && req_valid && req_ready && (req_op == 2'd3))
      $display("[%08h] dropped illegal op addr=%h", sim_time, req_addr);
  end
`else
`endif

endmodule
